// File: rtl/uart_frame_pkg.sv
// Shared types for the framed UART parameter loader.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_CHECKSUM = 2'd1,
        ERR_TIMEOUT  = 2'd2
    } err_code_t;

endpackage

// File: rtl/byte_timeout_timer.sv
// Inter-byte idle timer: counts idle cycles while enabled, pulses expired on the
// CYCLES-th consecutive idle cycle unless a byte (clear) lands in that same cycle.
module byte_timeout_timer #(
    parameter int CYCLES = 17360
) (
    input  logic clk,
    input  logic rstn,
    input  logic enable,
    input  logic clear,
    output logic expired
);
    localparam int W = $clog2(CYCLES);

    logic [W-1:0] cnt;

    // clear has priority so a byte on the expiry cycle still counts as on time
    assign expired = enable && !clear && (cnt == W'(CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (!enable || clear || expired) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/uart_frame_loader.sv
// Sync-hunting frame loader: assembles an MSB-first payload into a shadow register,
// optionally checks a trailing sum byte, and commits to params only on a good frame.
module uart_frame_loader
    import uart_frame_pkg::*;
#(
    parameter int          PAYLOAD_BYTES  = 26,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter bit          CHECKSUM_EN    = 1'b1,
    parameter int          TIMEOUT_CYCLES = 17360
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic [8*PAYLOAD_BYTES-1:0] params,
    output logic                       params_ready,
    output logic                       busy,
    output logic                       err,
    output logic [1:0]                 err_code,
    output logic [15:0]                frame_count
);
    localparam int PW    = 8 * PAYLOAD_BYTES;
    localparam int IDX_W = $clog2(PAYLOAD_BYTES + 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [7:0]       sum;
    logic [PW-1:0]    shadow;
    logic [PW-1:0]    shadow_merged;
    logic             expired;

    byte_timeout_timer #(.CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk     (clk),
        .rstn    (rstn),
        .enable  (state != HUNT),
        .clear   (rx_valid),
        .expired (expired)
    );

    // Shadow with the current byte dropped in, so a no-checksum frame can
    // commit its final byte on the same edge it arrives.
    always_comb begin
        shadow_merged = shadow;
        shadow_merged[{idx, 3'b000} +: 8] = rx_data;
    end

    assign busy = (state != HUNT);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= HUNT;
            idx          <= '0;
            sum          <= '0;
            shadow       <= '0;
            params       <= '0;
            params_ready <= 1'b0;
            err          <= 1'b0;
            err_code     <= ERR_NONE;
            frame_count  <= '0;
        end else begin
            params_ready <= 1'b0;
            err          <= 1'b0;
            case (state)
                HUNT: begin
                    if (rx_valid && rx_data == SYNC_BYTE) begin
                        state <= PAYLOAD;
                        idx   <= IDX_W'(PAYLOAD_BYTES - 1);
                        sum   <= '0;
                    end
                end
                PAYLOAD: begin
                    if (rx_valid) begin
                        shadow <= shadow_merged;
                        sum    <= sum + rx_data;
                        if (idx == '0) begin
                            if (CHECKSUM_EN) begin
                                state <= CHECK;
                            end else begin
                                params       <= shadow_merged;
                                params_ready <= 1'b1;
                                err_code     <= ERR_NONE;
                                frame_count  <= frame_count + 16'd1;
                                state        <= HUNT;
                            end
                        end else begin
                            idx <= idx - IDX_W'(1);
                        end
                    end else if (expired) begin
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                        state    <= HUNT;
                    end
                end
                CHECK: begin
                    if (rx_valid) begin
                        if (rx_data == sum) begin
                            params       <= shadow;
                            params_ready <= 1'b1;
                            err_code     <= ERR_NONE;
                            frame_count  <= frame_count + 16'd1;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_CHECKSUM;
                        end
                        state <= HUNT;
                    end else if (expired) begin
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                        state    <= HUNT;
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

endmodule

// File: doc/uart_frame_loader.md
# uart_frame_loader

Framed parameter loader that sits between `uart_receive` and the packet-generation logic. It replaces the bare byte-counting loader. It hunts for a sync byte, assembles a parametrised-length payload MSB-first into a shadow register, and optionally validates a trailing checksum byte. It enforces an inter-byte timeout and commits the payload to its output only on a good frame, so downstream logic never sees a partial or corrupt parameter set.

## Interface
- `PAYLOAD_BYTES`, 26: payload length in bytes, range 1..255.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `CHECKSUM_EN`, 1: 1 = trailing checksum byte is expected and checked; 0 = no checksum byte.
- `TIMEOUT_CYCLES`, 17360: maximum idle clk cycles between bytes inside a frame, about 2 byte times at 115200 baud on 100 MHz. Must be ≥ 2.

- `clk` input 1: system clock; the only clock.
- `rstn` input 1: synchronous, active-low reset.
- `rx_data` input 8: byte from the UART receiver.
- `rx_valid` input 1: one-cycle strobe qualifying `rx_data`.
- `params` output 8*PAYLOAD_BYTES: last committed payload. The first payload byte is at the top: `[8*PAYLOAD_BYTES-1 -: 8]`.
- `params_ready` output 1: one-cycle pulse when `params` updates.
- `busy` output 1: high while a frame is in progress (state ≠ HUNT).
- `err` output 1: one-cycle pulse when a frame is rejected.
- `err_code` output 2: 0 none, 1 checksum mismatch, 2 timeout. Holds its value until the next `err` or `params_ready`.
- `frame_count` output 16: count of good frames; wraps 16'hFFFF→0.

## Operation
- Reset (`rstn`=0 at a clk edge) returns every output and internal register to 0, including `params`, `err_code`, `frame_count`, and the shadow register. State goes to HUNT.
- HUNT:
  - A byte equal to `SYNC_BYTE` moves the block to PAYLOAD, loads idx = PAYLOAD_BYTES-1, clears sum, and clears the timer.
  - Any other byte is dropped silently, with no `err`.
- PAYLOAD:
  - Each byte is written to shadow[8*idx +: 8]; sum += byte, mod 256.
  - When idx = 0, go to CHECK if `CHECKSUM_EN`, otherwise commit.
  - Otherwise idx decrements.
  - Bytes equal to `SYNC_BYTE` are ordinary data here; there is no resync.
- CHECK:
  - If the byte equals sum, commit.
  - Otherwise raise `err` with code 1 and return to HUNT. `params` is unchanged.
- Commit: `params` ← shadow (with the last byte merged in the same edge when `CHECKSUM_EN`=0), `params_ready` pulses, `err_code` ← 0, `frame_count` increments, state → HUNT.
- Timeout:
  - In PAYLOAD or CHECK, the timer increments on every cycle without `rx_valid` and clears on every accepted byte.
  - When the timer reaches TIMEOUT_CYCLES-1 with no byte in that cycle: `err` with code 2, state → HUNT, shadow discarded.
  - If a byte arrives in the same cycle as expiry, the byte wins and the timer clears.
- `err` and `params_ready` are never asserted together.

## Timing
- Every decision is made on the edge that samples `rx_valid`=1. `params`, `params_ready`, `err`, and `err_code` are visible the following cycle, so latency is 1 cycle from the final byte.
- Back-to-back `rx_valid` on consecutive cycles is accepted; there is no backpressure.
- Minimum frame length is 1 + PAYLOAD_BYTES + CHECKSUM_EN bytes. A new sync byte can be accepted the cycle after a commit.
- Timeout `err` asserts exactly TIMEOUT_CYCLES cycles after the last accepted in-frame byte.
- If `rstn` goes low mid-frame, the frame is aborted with no `err` pulse.

## Structure
- Package `uart_frame_pkg`:
  - `state_t` enum {HUNT, PAYLOAD, CHECK}.
  - `err_code_t` enum {ERR_NONE=0, ERR_CHECKSUM=1, ERR_TIMEOUT=2}.
- idx width is $clog2(PAYLOAD_BYTES+1). Timer width is $clog2(TIMEOUT_CYCLES).
- Sub-module `byte_timeout_timer`:
  - Parameter `CYCLES`.
  - Ports `clk`, `rstn`, `enable`, `clear`, `expired` (one-cycle pulse).
- The frame FSM stays in the top module.

## Test plan
Bench parameters: PAYLOAD_BYTES=4, SYNC_BYTE=8'hA5, TIMEOUT_CYCLES=100, CHECKSUM_EN=1 unless noted.
- Good frame: A5 01 02 03 04 0A → `params`=32'h01020304; `params_ready` pulses once, 1 cycle after 0A; `frame_count`=1.
- Bad checksum: same frame ending in 0B → `err` pulses with code 1; `params` keeps its prior value; `frame_count` unchanged.
- Leading garbage and sync bytes as data: 00 FF 3C, then A5 A5 A5 A5 A5 94 → `params`=32'hA5A5A5A5 with a single `params_ready` and no `err`.
- Timeout: A5 01 02, then 100 idle cycles → `err` code 2 exactly 100 cycles after 02, `busy` drops. A following good frame A5 10 20 30 40 A0 → `params`=32'h10203040.
- Timeout boundary: a byte arriving exactly on the expiry cycle is accepted and produces no `err`.
- Reset and no-checksum: reset after A5 01 → all outputs 0, no `err`. Then, with CHECKSUM_EN=0, A5 11 22 33 44 → `params`=32'h11223344, ready 1 cycle after 44.
